// File: rtl/bcd_pkg.sv
// Shared BCD constants, digit type and converter FSM states, used by the
// BCD-to-binary converter and the binary-to-BCD score path.
package bcd_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 14;
    localparam int ITERS      = 14;
    localparam int BCD_W      = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W      = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic digit_invalid(input bcd_digit_t x);
        return (x > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for right-shifting BCD-to-binary conversion:
// a digit that reads 8 or more after the shift has 3 subtracted.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd8) begin
            dout = din - 4'd3;
        end
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Four-digit BCD to 14-bit binary converter (shift-and-subtract-3, one bit per cycle).
// Define BCD_TO_BIN_ERR_CHECK_EN to flag digits above 9 and return err=1 after one cycle.
module bcd_to_bin
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic [3:0]       c,
    input  logic [3:0]       d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIN_W-1:0] bnum,
    output logic             err
);

    state_t            state_q, state_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIN_W-1:0]  bnum_q, bnum_d;
    logic              out_valid_q, out_valid_d;
    logic              accept;
    logic              bad_in;

    logic [BCD_W-1:0]  bcd_sh;
    logic [BIN_W-1:0]  bin_sh;
    logic [BCD_W-1:0]  bcd_adj;

`ifdef BCD_TO_BIN_ERR_CHECK_EN
    logic err_q, err_d;
    assign bad_in = digit_invalid(a) | digit_invalid(b) | digit_invalid(c) | digit_invalid(d);
`else
    assign bad_in = 1'b0;
`endif

    assign accept = in_valid && in_ready;

    // The BCD LSB falls into the binary MSB on each shift.
    assign {bcd_sh, bin_sh} = {1'b0, bcd_q, bin_q[BIN_W-1:1]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (bcd_sh[gi*DIGIT_W +: DIGIT_W]),
                .dout (bcd_adj[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bcd_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            bnum_q      <= '0;
            out_valid_q <= 1'b0;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bcd_q       <= bcd_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
            bnum_q      <= bnum_d;
            out_valid_q <= out_valid_d;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = bad_in ? ST_DONE : ST_CONV;
                end
            end
            ST_CONV: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bcd_d       = bcd_q;
        bin_d       = bin_q;
        cnt_d       = cnt_q;
        bnum_d      = bnum_q;
        out_valid_d = out_valid_q;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    bcd_d = {a, b, c, d};
                    bin_d = '0;
                    cnt_d = CNT_W'(ITERS - 1);
`ifdef BCD_TO_BIN_ERR_CHECK_EN
                    err_d = 1'b0;
`endif
                end
            end
            ST_CONV: begin
                bcd_d = bcd_adj;
                bin_d = bin_sh;
                if (cnt_q == '0) begin
                    bnum_d      = bin_sh;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                // Entering DONE without a result only happens on the bad-digit path.
                if (!out_valid_q) begin
                    bnum_d      = '0;
                    out_valid_d = 1'b1;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
                    err_d       = 1'b1;
`endif
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = out_valid_q;
        bnum      = bnum_q;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
        err       = err_q;
`else
        err       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboarded bench for bcd_to_bin: directed cases plus randomized digits,
// checked against the decimal value a*1000+b*100+c*10+d.
module tb_bcd_to_bin;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  a, b, c, d;
    logic        in_ready, out_valid, err;
    logic [13:0] bnum;

    bcd_to_bin dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bnum      (bnum),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        bit e;
        int lat;
        bit chk_val;
        int acc;
        int num;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_tx     = 0;
    bit   rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                     name, act, act, expv, expv, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] ta, tb, tc, td, input int acc);
        exp_t e;
        bit   bad;
        bad       = (ta > 9) || (tb > 9) || (tc > 9) || (td > 9);
        e.acc     = acc;
        e.num     = n_tx;
        e.chk_val = 1'b1;
        e.e       = 1'b0;
        e.lat     = 14;
        e.val     = int'(ta) * 1000 + int'(tb) * 100 + int'(tc) * 10 + int'(td);
`ifdef BCD_TO_BIN_ERR_CHECK_EN
        if (bad) begin
            e.val = 0;
            e.e   = 1'b1;
            e.lat = 1;
        end
`else
        if (bad) e.chk_val = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [3:0] rdig();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    // Random backpressure changes just after the edge, so it is stable at the sampling edge.
    always @(posedge clk) begin
        #2;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [3:0] ta, tb, tc, td);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=0 required 1 at cycle %0d", cyc);
            return;
        end
        a = ta; b = tb; c = tc; d = td;
        in_valid = 1'b1;
        exp_q.push_back(model(ta, tb, tc, td, cyc + 1));
        n_tx++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble the operand bus; the result in flight must not change.
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        c = 4'($urandom_range(0, 15));
        d = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d out_valid=%0b required 0/0", exp_q.size(), out_valid);
        end
    endtask

    // Monitor: pops on the rising edge of out_valid, then checks stability while held.
    initial begin : monitor
        exp_t cur;
        bit   have_cur = 1'b0;
        bit   prev_ov  = 1'b0;
        bit   hs       = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov  = 1'b0;
                hs       = 1'b0;
                have_cur = 1'b0;
                continue;
            end
            if (hs) begin
                check("in_ready_after_handshake", 32'(in_ready), 32'd1);
                check("out_valid_after_handshake", 32'(out_valid), 32'd0);
                hs = 1'b0;
            end
            if (out_valid) begin
                if (!prev_ov) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_output: bnum=%0d err=%0b with no request pending", bnum, err);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                        $display("tx %0d: bnum=%0d err=%0b expected %0d err=%0b latency=%0d",
                                 cur.num, bnum, err, cur.val, cur.e, cyc - cur.acc);
                    end
                end
                if (have_cur) begin
                    if (cur.chk_val) check("bnum", 32'(bnum), 32'(cur.val));
                    check("err", 32'(err), 32'(cur.e));
                    check("in_ready_while_done", 32'(in_ready), 32'd0);
                end
                if (out_ready) hs = 1'b1;
            end
            prev_ov = out_valid;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; d = '0;
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_bnum", 32'(bnum), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        send(4'd9, 4'd9, 4'd9, 4'd9);
        wait_drain();

        send(4'd0, 4'd0, 4'd0, 4'd0);
        send(4'd1, 4'd2, 4'd3, 4'd4);
        wait_drain();

        // Hold the 0500 result under backpressure while a stray request is offered.
        @(posedge clk);
        #2 out_ready = 1'b0;
        send(4'd0, 4'd5, 4'd0, 4'd0);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("hold_out_valid_seen", 32'(out_valid), 32'd1);
        a = 4'd7; b = 4'd7; c = 4'd7; d = 4'd7;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain();

        // Abort a 9999 conversion mid-way with reset.
        send(4'd9, 4'd9, 4'd9, 4'd9);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_bnum", 32'(bnum), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        send(4'd0, 4'd0, 4'd4, 4'd2);
        wait_drain();

        send(4'hA, 4'd1, 4'd2, 4'd3);
        wait_drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(rdig(), rdig(), rdig(), rdig());
        end
        wait_drain();
        rand_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
